// File: rtl/mem_map_pkg.sv
// Address map, register layouts and decode tags shared by the data-side memory system.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'h0000_0400;
    localparam logic [31:0] LED_ADDR   = MMIO_BASE + 32'h00;
    localparam logic [31:0] SW_ADDR    = MMIO_BASE + 32'h04;
    localparam logic [31:0] TCTRL_ADDR = MMIO_BASE + 32'h08;
    localparam logic [31:0] TCNT_ADDR  = MMIO_BASE + 32'h0C;
    localparam logic [31:0] TCMP_ADDR  = MMIO_BASE + 32'h10;
    localparam logic [31:0] TSTAT_ADDR = MMIO_BASE + 32'h14;

    localparam int TCTRL_EN          = 0;
    localparam int TCTRL_AUTO_RELOAD = 1;
    localparam int TCTRL_IRQ_EN      = 2;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } tctrl_t;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_TCTRL, SEL_TCNT, SEL_TCMP, SEL_TSTAT
    } sel_e;

endpackage

// File: rtl/timer_unit.sv
// Prescaled 32-bit timer with compare match, sticky W1C status and interrupt output.
module timer_unit
    import mem_map_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_tctrl,
    input  logic        we_tcnt,
    input  logic        we_tcmp,
    input  logic        we_tstat,
    input  logic [31:0] wdata,
    output tctrl_t      tctrl,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic        match,
    output logic        irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc;
    logic            tick;
    logic            hit;

    // A TCTRL write restarts the prescaler, so it also suppresses the wrap tick.
    assign tick = tctrl.en && (presc == PS_LAST) && !we_tctrl;
    // A CPU write to TCNT pre-empts both the increment and the compare.
    assign hit  = tick && !we_tcnt && (tcnt == tcmp);
    assign irq  = match & tctrl.irq_en;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (we_tctrl) begin
            presc <= '0;
        end else if (tctrl.en) begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tctrl <= '0;
            tcnt  <= '0;
            tcmp  <= '1;
            match <= 1'b0;
        end else begin
            if (we_tctrl) begin
                tctrl.en          <= wdata[TCTRL_EN];
                tctrl.auto_reload <= wdata[TCTRL_AUTO_RELOAD];
                tctrl.irq_en      <= wdata[TCTRL_IRQ_EN];
            end
            if (we_tcnt) begin
                tcnt <= wdata;
            end else if (tick) begin
                tcnt <= (hit && tctrl.auto_reload) ? '0 : tcnt + 32'd1;
            end
            if (we_tcmp) begin
                tcmp <= wdata;
            end
            // Set has priority over a coincident W1C clear.
            if (hit) begin
                match <= 1'b1;
            end else if (we_tstat && wdata[0]) begin
                match <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_mem_bus.sv
// Data-side memory system: word-addressed RAM plus LED, switch and timer MMIO, zero-latency reads.
module data_mem_bus
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int LED_W     = 10,
    parameter int SW_W      = 10,
    parameter int PRESCALE  = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq
);

    localparam int          IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);

    logic [31:0]      waddr;
    logic [IDX_W-1:0] ram_idx;
    sel_e             sel;
    logic [31:0]      ram [RAM_WORDS];
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    tctrl_t           tctrl;
    logic [31:0]      tcnt;
    logic [31:0]      tcmp;
    logic             match;

    assign waddr   = Addr & 32'hFFFF_FFFC;
    assign ram_idx = waddr[IDX_W+1:2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = SEL_NONE;
        if (waddr[31:2] < RAM_LIMIT) begin
            sel = SEL_RAM;
        end else begin
            case (waddr)
                LED_ADDR:   sel = SEL_LED;
                SW_ADDR:    sel = SEL_SW;
                TCTRL_ADDR: sel = SEL_TCTRL;
                TCNT_ADDR:  sel = SEL_TCNT;
                TCMP_ADDR:  sel = SEL_TCMP;
                TSTAT_ADDR: sel = SEL_TSTAT;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    // NOTE: the RAM has no reset branch so it maps onto a plain memory macro; contents survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && sel == SEL_RAM) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_out <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (MemWrite && sel == SEL_LED) begin
                led_out <= WriteData[LED_W-1:0];
            end
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    timer_unit #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .we_tctrl (MemWrite && sel == SEL_TCTRL),
        .we_tcnt  (MemWrite && sel == SEL_TCNT),
        .we_tcmp  (MemWrite && sel == SEL_TCMP),
        .we_tstat (MemWrite && sel == SEL_TSTAT),
        .wdata    (WriteData),
        .tctrl    (tctrl),
        .tcnt     (tcnt),
        .tcmp     (tcmp),
        .match    (match),
        .irq      (timer_irq)
    );

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:   ReadData = ram[ram_idx];
            SEL_LED:   ReadData = 32'(led_out);
            SEL_SW:    ReadData = 32'(sw_sync);
            SEL_TCTRL: ReadData = 32'(tctrl);
            SEL_TCNT:  ReadData = tcnt;
            SEL_TCMP:  ReadData = tcmp;
            SEL_TSTAT: ReadData = 32'(match);
            default:   ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_bus.sv
// Randomised and directed bench for data_mem_bus against a cycle-level behavioural model.
module tb_data_mem_bus;
    import mem_map_pkg::*;

    localparam int RAM_WORDS = 256;
    localparam int LED_W     = 10;
    localparam int SW_W      = 10;
    localparam int PRESCALE  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             MemWrite;
    logic [31:0]      Addr;
    logic [31:0]      WriteData;
    logic [31:0]      ReadData;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led_out;
    logic             timer_irq;

    int checks = 0;
    int errors = 0;

    data_mem_bus #(
        .RAM_WORDS (RAM_WORDS),
        .LED_W     (LED_W),
        .SW_W      (SW_W),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             en;
        logic             ar;
        logic             ie;
        logic [31:0]      cnt;
        logic [31:0]      cmp;
        logic             match;
        logic [31:0]      div;
        logic [LED_W-1:0] led;
        logic [SW_W-1:0]  s1;
        logic [SW_W-1:0]  s2;
    } model_t;

    model_t      m;
    logic [31:0] mram   [RAM_WORDS];
    bit          mvalid [RAM_WORDS];

    function automatic model_t reset_model();
        model_t r = '0;
        r.cmp = 32'hFFFF_FFFF;
        return r;
    endfunction

    // One clock edge of the memory system, straight from the behavioural rules.
    function automatic model_t next_model(model_t c, logic we, logic [31:0] a,
                                          logic [31:0] d, logic [SW_W-1:0] sw);
        model_t      n    = c;
        logic [31:0] w    = {a[31:2], 2'b00};
        bit          wctl = we && w == TCTRL_ADDR;
        bit          wcnt = we && w == TCNT_ADDR;
        bit          tick = c.en && c.div == 32'(PRESCALE - 1) && !wctl;
        bit          set  = 0;
        n.s1 = sw;
        n.s2 = c.s1;
        if (wctl) n.div = 0;
        else if (c.en) n.div = (c.div + 1) % PRESCALE;
        if (tick && !wcnt) begin
            if (c.cnt == c.cmp) begin
                set = 1;
                n.match = 1;
                n.cnt = c.ar ? 32'd0 : c.cnt + 1;
            end else begin
                n.cnt = c.cnt + 1;
            end
        end
        if (we && w == LED_ADDR) n.led = d[LED_W-1:0];
        if (wctl) {n.ie, n.ar, n.en} = d[2:0];
        if (wcnt) n.cnt = d;
        if (we && w == TCMP_ADDR) n.cmp = d;
        if (we && w == TSTAT_ADDR && d[0] && !set) n.match = 0;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m <= reset_model();
        end else begin
            m <= next_model(m, MemWrite, Addr, WriteData, sw_in);
            if (MemWrite && Addr[31:10] == 22'd0) begin
                mram[Addr[9:2]]   <= WriteData;
                mvalid[Addr[9:2]] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_read(logic [31:0] a, output bit known);
        logic [31:0] w = a & 32'hFFFF_FFFC;
        known = 1;
        if (w < 32'(RAM_WORDS * 4)) begin
            known = mvalid[w[9:2]];
            return mram[w[9:2]];
        end
        case (w)
            LED_ADDR:   return 32'(m.led);
            SW_ADDR:    return 32'(m.s2);
            TCTRL_ADDR: return {29'd0, m.ie, m.ar, m.en};
            TCNT_ADDR:  return m.cnt;
            TCMP_ADDR:  return m.cmp;
            TSTAT_ADDR: return {31'd0, m.match};
            default:    return 32'd0;
        endcase
    endfunction

    // All bus tasks start and end just after a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        Addr = a;
        WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        MemWrite = 1'b0;
        Addr = a;
        #1;
        d = ReadData;
    endtask

    task automatic idle(input int n);
        MemWrite = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic timer_setup(input logic [31:0] cnt, input logic [31:0] cmp, input logic [2:0] ctl);
        bus_write(TCTRL_ADDR, 32'd0);
        bus_write(TSTAT_ADDR, 32'd1);
        bus_write(TCNT_ADDR, cnt);
        bus_write(TCMP_ADDR, cmp);
        bus_write(TCTRL_ADDR, 32'(ctl));
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        addrs = '{LED_ADDR, SW_ADDR, TCTRL_ADDR, TCNT_ADDR, TCMP_ADDR, TSTAT_ADDR};
        exps  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        checks++;
        if (led_out !== '0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: led=%h irq=%b, required led=0 irq=0", led_out, timer_irq);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], d);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL reset_reg @%h: got %h, required %h", addrs[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] e;
        bit          known;
        bus_write(32'h14, 32'h1234_5678);
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_read(32'h10, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_0x10: got %h, required deadbeef", d); end
        bus_read(32'h13, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_0x13: got %h, required deadbeef", d); end
        bus_read(32'h14, d);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_0x14: got %h, required 12345678", d); end
        idle(1);
        // Store and load of the same word in one cycle returns the old contents.
        MemWrite = 1'b1; Addr = 32'h10; WriteData = 32'h0BAD_F00D;
        #1;
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_same_cycle: got %h, required deadbeef", ReadData); end
        @(negedge clk);
        bus_write(32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, RAM_WORDS - 1)) << 2;
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, $urandom);
            end else begin
                a = a | 32'($urandom_range(0, 3));
                bus_read(a, d);
                e = exp_read(a, known);
                if (known) begin
                    checks++;
                    if (d !== e) begin errors++; $display("FAIL ram_random @%h: got %h, required %h", a, d, e); end
                end
                idle(1);
            end
        end
    endtask

    task automatic test_map();
        logic [31:0] d;
        MemWrite = 1'b1; Addr = LED_ADDR; WriteData = 32'h3FF;
        #1;
        checks++;
        if (led_out !== 10'h000 || ReadData !== 32'd0) begin
            errors++;
            $display("FAIL led_before_edge: led=%h read=%h, required 0 and 0", led_out, ReadData);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        checks++;
        if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_after_edge: got %h, required 3ff", led_out); end
        bus_read(32'h403, d);
        checks++;
        if (d !== 32'h3FF) begin errors++; $display("FAIL led_read: got %h, required 000003ff", d); end
        idle(1);
        bus_write(32'h800, 32'hFFFF_FFFF);
        bus_write(32'h1000_0400, 32'h0);
        bus_read(32'h800, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", d); end
        bus_read(32'h1000_0400, d);
        checks++;
        if (d !== 32'd0 || led_out !== 10'h3FF) begin
            errors++;
            $display("FAIL upper_bits_alias: read=%h led=%h, required 0 and 3ff", d, led_out);
        end
        idle(1);
    endtask

    task automatic test_switches();
        logic [31:0] d;
        sw_in = 10'h155;
        idle(1);
        bus_read(SW_ADDR, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL sw_one_edge: got %h, required 0", d); end
        idle(1);
        bus_read(SW_ADDR, d);
        checks++;
        if (d !== 32'h155) begin errors++; $display("FAIL sw_two_edges: got %h, required 155", d); end
        idle(1);
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] seq [8];
        seq = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0};
        timer_setup(32'd0, 32'd3, 3'b111);
        for (int k = 0; k < 8; k++) begin
            idle(1);
            bus_read(TCNT_ADDR, d);
            checks++;
            if (d !== seq[k]) begin errors++; $display("FAIL tcnt_step %0d: got %h, required %h", k + 1, d, seq[k]); end
        end
        bus_read(TSTAT_ADDR, d);
        checks++;
        if (d !== 32'd1 || timer_irq !== 1'b1) begin
            errors++;
            $display("FAIL timer_match: tstat=%h irq=%b, required 1 and 1", d, timer_irq);
        end
        idle(1);
        bus_write(TSTAT_ADDR, 32'd1);
        bus_read(TSTAT_ADDR, d);
        checks++;
        if (d !== 32'd0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_w1c: tstat=%h irq=%b, required 0 and 0", d, timer_irq);
        end
        idle(1);
        timer_setup(32'd0, 32'd3, 3'b101);
        idle(8);
        bus_read(TCNT_ADDR, d);
        checks++;
        if (d !== 32'd4 || timer_irq !== 1'b1) begin
            errors++;
            $display("FAIL timer_no_reload: tcnt=%h irq=%b, required 4 and 1", d, timer_irq);
        end
        idle(1);
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        logic [31:0] s;
        timer_setup(32'd5, 32'd5, 3'b111);
        idle(1);
        bus_write(TCNT_ADDR, 32'h100);
        bus_read(TCNT_ADDR, d);
        bus_read(TSTAT_ADDR, s);
        checks++;
        if (d !== 32'h100 || s !== 32'd0) begin
            errors++;
            $display("FAIL tcnt_write_on_tick: tcnt=%h tstat=%h, required 100 and 0", d, s);
        end
        idle(1);
        timer_setup(32'd9, 32'd9, 3'b111);
        idle(1);
        bus_write(TSTAT_ADDR, 32'd1);
        bus_read(TSTAT_ADDR, s);
        bus_read(TCNT_ADDR, d);
        checks++;
        if (s !== 32'd1 || d !== 32'd0) begin
            errors++;
            $display("FAIL w1c_vs_match: tstat=%h tcnt=%h, required 1 and 0", s, d);
        end
        idle(1);
        timer_setup(32'd7, 32'd7, 3'b111);
        idle(1);
        bus_write(TCMP_ADDR, 32'h50);
        bus_read(TSTAT_ADDR, s);
        bus_read(TCMP_ADDR, d);
        checks++;
        if (s !== 32'd1 || d !== 32'h50) begin
            errors++;
            $display("FAIL tcmp_write_on_tick: tstat=%h tcmp=%h, required 1 and 50", s, d);
        end
        idle(1);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [31:0] s;
        timer_setup(32'hFFFF_FFFF, 32'd5, 3'b001);
        idle(1);
        bus_read(TCNT_ADDR, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_before_tick: got %h, required ffffffff", d); end
        idle(1);
        bus_read(TCNT_ADDR, d);
        bus_read(TSTAT_ADDR, s);
        checks++;
        if (d !== 32'd0 || s !== 32'd0) begin
            errors++;
            $display("FAIL wrap_tick: tcnt=%h tstat=%h, required 0 and 0", d, s);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        bit          known;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) sw_in = SW_W'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: a = ($urandom_range(0, RAM_WORDS - 1) << 2) | $urandom_range(0, 3);
                3:       a = LED_ADDR;
                4:       a = SW_ADDR;
                5:       a = TCTRL_ADDR;
                6:       a = ($urandom_range(0, 1) == 1) ? TCNT_ADDR : TCMP_ADDR;
                7:       a = TSTAT_ADDR;
                8:       a = 32'h418 + 32'($urandom_range(0, 100)) * 4;
                default: a = 32'h8000_0400 | ($urandom_range(0, 7) << 2);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = (a == TCNT_ADDR || a == TCMP_ADDR) ? 32'($urandom_range(0, 15)) : $urandom;
                bus_write(a, d);
            end else begin
                bus_read(a, d);
                e = exp_read(a, known);
                if (known) begin
                    checks++;
                    if (d !== e) begin errors++; $display("FAIL random_read @%h: got %h, required %h", a, d, e); end
                end
                idle(1);
            end
            checks++;
            if (led_out !== m.led || timer_irq !== (m.match & m.ie)) begin
                errors++;
                $display("FAIL random_outputs: led=%h irq=%b, required led=%h irq=%b",
                         led_out, timer_irq, m.led, m.match & m.ie);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] e;
        bit          known;
        bus_write(LED_ADDR, 32'h2A5);
        timer_setup(32'd0, 32'd0, 3'b111);
        idle(2);
        checks++;
        if (timer_irq !== 1'b1 || led_out !== 10'h2A5) begin
            errors++;
            $display("FAIL pre_reset_state: irq=%b led=%h, required 1 and 2a5", timer_irq, led_out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (led_out !== '0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: led=%h irq=%b, required 0 and 0", led_out, timer_irq);
        end
        bus_read(TCMP_ADDR, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tcmp: got %h, required ffffffff", d); end
        bus_read(TCNT_ADDR, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_tcnt: got %h, required 0", d); end
        bus_read(32'h10, d);
        e = exp_read(32'h10, known);
        checks++;
        if (!known || d !== e) begin errors++; $display("FAIL ram_kept: got %h, required %h", d, e); end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
    endtask

    initial begin
        reset = 1'b0;
        MemWrite = 1'b0;
        Addr = '0;
        WriteData = '0;
        sw_in = '0;
        for (int i = 0; i < RAM_WORDS; i++) mvalid[i] = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_ram();
        test_map();
        test_switches();
        test_timer();
        test_collisions();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
